// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, req/valid imem port, valid/ready issue to Execute.
// Optional WAIT-state response timeout is built when FETCH_TIMEOUT_EN is defined.
module fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        pc_update,
    input  logic [31:0] sonuc,
    input  logic        hata,
    output logic        halted,
    output logic        misalign,
    output logic        imem_timeout,
    output logic [31:0] inst_count
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        bad_target;

    assign imem_req   = (state == S_FETCH);
    assign imem_addr  = imem_req ? pc : 32'h0;
    assign bad_target = pc_update && (sonuc[1:0] != 2'b00);

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;
    logic          wait_expired;

    // wait_cnt holds the number of WAIT cycles already completed
    assign wait_expired = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign imem_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            inst       <= 32'h0;
            inst_pc    <= 32'h0;
            inst_valid <= 1'b0;
            halted     <= 1'b0;
            misalign   <= 1'b0;
            inst_count <= 32'h0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt     <= '0;
            imem_timeout <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_FETCH: begin
                    state <= S_WAIT;
`ifdef FETCH_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    if (imem_valid) begin
                        inst       <= imem_rdata;
                        inst_pc    <= pc;
                        inst_valid <= 1'b1;
                        state      <= S_ISSUE;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (wait_expired) begin
                        imem_timeout <= 1'b1;
                        halted       <= 1'b1;
                        state        <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                S_ISSUE: begin
                    if (inst_ready) begin
                        inst_valid <= 1'b0;
                        if (hata) begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else if (bad_target) begin
                            misalign   <= 1'b1;
                            halted     <= 1'b1;
                            inst_count <= inst_count + 32'd1;
                            state      <= S_HALT;
                        end else begin
                            pc         <= pc_update ? sonuc : pc + 32'd4;
                            inst_count <= inst_count + 32'd1;
                            state      <= S_FETCH;
                        end
                    end
                end
                S_HALT: begin
                    inst_valid <= 1'b0;
                    halted     <= 1'b1;
                end
                default: state <= S_HALT;
            endcase
        end
    end

endmodule
